// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the program counter, drives a combinational
//   byte-addressed instruction memory and captures {pc, instr} pairs into a
//   small prefetch FIFO that is handed to decode over a valid/ready handshake.
//   A taken branch/jump (redirect) reloads the PC and flushes the FIFO.
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   defined   - a redirect to a non word-aligned target loads the PC as given,
//               raises a sticky halt (no further fetch) and fetch_misaligned;
//               a later aligned redirect clears both.
//   undefined - redirect targets are forced word-aligned; fetch_misaligned = 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_pc           address to instruction memory (current PC)
//   imem_instr        instruction returned combinationally for imem_pc
//   redirect_valid    branch/jump taken this cycle
//   redirect_pc       redirect target
//   out_valid         head entry valid for decode
//   out_ready         decode accepts head entry
//   out_pc, out_instr head entry contents (0 when the FIFO is empty)
//   fetch_misaligned  misaligned redirect trap flag
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'hBFC00000,
    parameter int                       DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] imem_pc,
    input  logic [31:0]              imem_instr,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic [31:0]              out_instr,
    output logic                     fetch_misaligned
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] ent_pc_q    [DEPTH];
    logic [ADDRESS_WIDTH-1:0] ent_pc_d    [DEPTH];
    logic [31:0]              ent_instr_q [DEPTH];
    logic [31:0]              ent_instr_d [DEPTH];

    logic                     not_empty;
    logic                     push;
    logic                     pop;
    logic                     halted;
    logic [ADDRESS_WIDTH-1:0] redirect_target;

`ifdef MISALIGN_TRAP_EN
    logic halted_q, halted_d;
    logic redirect_misaligned;

    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    assign redirect_target     = redirect_pc;
    assign halted              = halted_q;
    assign fetch_misaligned    = halted_q;

    // The trap flag is simply the sticky halt: set by a misaligned redirect,
    // cleared by an aligned one, untouched otherwise.
    always_comb begin
        halted_d = halted_q;
        if (redirect_valid) begin
            halted_d = redirect_misaligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    // Drop the low two address bits so fetch always stays word-aligned.
    assign redirect_target  = redirect_pc & ~ADDRESS_WIDTH'(3);
    assign halted           = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    assign imem_pc   = pc_q;
    assign not_empty = (count_q != '0);
    // A redirect voids the head entry for this cycle, so no pop can happen.
    assign out_valid = not_empty & ~redirect_valid;
    assign out_pc    = not_empty ? ent_pc_q[rd_ptr_q]    : '0;
    assign out_instr = not_empty ? ent_instr_q[rd_ptr_q] : '0;
    assign pop       = out_valid & out_ready;
    // A full FIFO can still accept a new entry when the head leaves this cycle.
    assign push      = ~redirect_valid & ~halted & ((count_q < DEPTH_C) | pop);

    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        pc_d        = pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;

        if (redirect_valid) begin
            pc_d     = redirect_target;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                ent_pc_d[wr_ptr_q]    = pc_q;
                ent_instr_d[wr_ptr_q] = imem_instr;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                pc_d                  = pc_q + ADDRESS_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // Pointers wrap naturally because DEPTH is a power of two.
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            // NOTE: entry storage is reset as well, so the head mux never
            // exposes X after reset and the array stays ordinary flops.
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_q[i]    <= '0;
                ent_instr_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            pc_q        <= pc_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            ent_pc_q    <= ent_pc_d;
            ent_instr_q <= ent_instr_d;
        end
    end

endmodule
